// File: rtl/syn_debug_monitor_pkg.sv
// Shared types and constants for the board-side debug monitor: display mode
// encodings, default datamem address width and button slot indices.
package syn_debug_monitor_pkg;

  localparam int DBG_MODE_BIT = 3;
  localparam int DM_ADDR_BIT  = 10;

  typedef enum logic [DBG_MODE_BIT-1:0] {
    DBG_MODE_PC   = 3'd0,
    DBG_MODE_RF   = 3'd1,
    DBG_MODE_DM   = 3'd2,
    DBG_MODE_DISP = 3'd3,
    DBG_MODE_CYC  = 3'd4
  } dbg_mode_e;

  localparam int NUM_BTN = 2;
  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;

  // One-hot active-low anode pattern for digit d.
  function automatic logic [7:0] digit_enable_n(input logic [2:0] d);
    return ~(8'b1 << d);
  endfunction

endpackage

// File: rtl/cmb_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment decoder, bit order {g,f,e,d,c,b,a}.
// Shared by every board display that shows hex digits.
module cmb_hex_to_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    seg_n = 7'h7F;
    case (nibble)
      4'h0: seg_n = ~7'h3F;
      4'h1: seg_n = ~7'h06;
      4'h2: seg_n = ~7'h5B;
      4'h3: seg_n = ~7'h4F;
      4'h4: seg_n = ~7'h66;
      4'h5: seg_n = ~7'h6D;
      4'h6: seg_n = ~7'h7D;
      4'h7: seg_n = ~7'h07;
      4'h8: seg_n = ~7'h7F;
      4'h9: seg_n = ~7'h6F;
      4'hA: seg_n = ~7'h77;
      4'hB: seg_n = ~7'h7C;
      4'hC: seg_n = ~7'h39;
      4'hD: seg_n = ~7'h5E;
      4'hE: seg_n = ~7'h79;
      4'hF: seg_n = ~7'h71;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/syn_debug_monitor.sv
// Board-side debug monitor: steps regfile/datamem debug indices from buttons, counts
// CPU cycles and scans the selected word onto an 8-digit 7-segment display.
// Optional button debouncing is enabled by defining DBG_DEBOUNCE_EN.
module syn_debug_monitor
  import syn_debug_monitor_pkg::*;
#(
  parameter int DmAddrBit   = DM_ADDR_BIT,
  parameter int ScanPeriod  = 50000,
  parameter int DebounceCyc = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           mode,
  input  logic                 btn_inc,
  input  logic                 btn_dec,
  input  logic                 cpu_en,
  input  logic                 halt,
  input  logic [31:0]          pc_dbg,
  input  logic [31:0]          regfile_data_dbg,
  input  logic [31:0]          datamem_data_dbg,
  input  logic [31:0]          display,
  output logic [4:0]           regfile_req_dbg,
  output logic [DmAddrBit-1:0] datamem_addr_dbg,
  output logic [7:0]           an_n,
  output logic [7:0]           seg_n
);

  localparam int SCAN_W = (ScanPeriod > 2) ? $clog2(ScanPeriod) : 1;

  dbg_mode_e mode_e;
  assign mode_e = dbg_mode_e'(mode);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_pulse;
  assign btn_raw = {btn_dec, btn_inc};

  // Per-button conditioning: synchronize, optionally debounce, then rising-edge detect.
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    logic sync1_q, sync2_q, prev_q, level;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[b];
        sync2_q <= sync1_q;
      end
    end

`ifdef DBG_DEBOUNCE_EN
    localparam int DB_W = $clog2(DebounceCyc + 1);
    logic [DB_W-1:0] db_cnt_q;
    logic            level_q;

    // The new level must persist DebounceCyc consecutive cycles; any bounce restarts.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q <= '0;
        level_q  <= 1'b0;
      end else if (sync2_q == level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DebounceCyc - 1)) begin
        db_cnt_q <= '0;
        level_q  <= sync2_q;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
    assign level = level_q;
`else
    logic unused_debounce;
    assign unused_debounce = ^DebounceCyc;
    assign level = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= level;
    end

    assign btn_pulse[b] = level & ~prev_q;
  end

  // Index stepping; simultaneous inc and dec cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regfile_req_dbg  <= '0;
      datamem_addr_dbg <= '0;
    end else if (btn_pulse[BTN_INC] ^ btn_pulse[BTN_DEC]) begin
      case (mode_e)
        DBG_MODE_RF:
          regfile_req_dbg <= btn_pulse[BTN_INC] ? regfile_req_dbg + 5'd1
                                                : regfile_req_dbg - 5'd1;
        DBG_MODE_DM:
          datamem_addr_dbg <= btn_pulse[BTN_INC] ? datamem_addr_dbg + 1'b1
                                                 : datamem_addr_dbg - 1'b1;
        default: ;
      endcase
    end
  end

  logic [31:0] cycle_cnt;
  logic [31:0] value_d, value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cycle_cnt <= '0;
    else if (cpu_en && !halt) cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_comb begin
    value_d = '0;
    case (mode_e)
      DBG_MODE_PC:   value_d = pc_dbg;
      DBG_MODE_RF:   value_d = regfile_data_dbg;
      DBG_MODE_DM:   value_d = datamem_data_dbg;
      DBG_MODE_DISP: value_d = display;
      DBG_MODE_CYC:  value_d = cycle_cnt;
      default:       value_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  // Display scan: outputs are reloaded only when the digit index advances.
  logic [SCAN_W-1:0] scan_cnt_q;
  logic [2:0]        digit_q;
  logic [3:0]        nibble;
  logic [6:0]        hex_seg_n;

  assign nibble = value_q[{digit_q, 2'b00} +: 4];

  cmb_hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg_n  (hex_seg_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      digit_q    <= '0;
      an_n       <= 8'hFF;
      seg_n      <= 8'hFF;
    end else if (scan_cnt_q == SCAN_W'(ScanPeriod - 1)) begin
      scan_cnt_q <= '0;
      digit_q    <= digit_q + 3'd1;
      an_n       <= digit_enable_n(digit_q);
      seg_n      <= {~((digit_q == 3'd0) && halt), hex_seg_n};
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

endmodule
